// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the streaming FIFO with occupancy monitor:
// default geometry/threshold values, the stall counter type, the output
// register load-source encoding and the occupancy-counter width helper.
package stream_fifo_pkg;

    localparam int STALL_W_DEF   = 32;
    localparam int AE_THRESH_DEF = 2;
    localparam int AF_MARGIN_DEF = 2;

    typedef logic [STALL_W_DEF-1:0] stall_cnt_t;

    typedef enum logic [1:0] {
        OUT_HOLD,
        OUT_FROM_PF,
        OUT_BYPASS,
        OUT_EMPTY
    } out_src_e;

    // Width needed to represent occupancies 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage array: one write port and one read port whose
// read data is registered. The array itself has no reset.
module sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: the read data register only updates when a read is issued,
    // so it doubles as the prefetch stage in front of the output register.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/streaming_fifo_mon.sv
// First-word-fall-through AXI-Stream FIFO with programmable almost-full /
// almost-empty flags, synchronous flush and a sizing monitor (peak occupancy
// and input-stall cycle count). Storage is a RAM with registered read data
// feeding a registered output stage; a bypass path lets a word pushed into an
// empty FIFO reach the output register directly, giving one-cycle latency.
// Every word is still written to the RAM so the pointers advance uniformly.
module streaming_fifo_mon
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16384,
    parameter int AF_THRESH = DEPTH - AF_MARGIN_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF,
    parameter int STALL_W   = STALL_W_DEF,
    localparam int CNT_W    = clog2_cnt(DEPTH)
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in0_V_V_TDATA,
    input  logic               in0_V_V_TVALID,
    output logic               in0_V_V_TREADY,
    output logic [WIDTH-1:0]   out_V_V_TDATA,
    output logic               out_V_V_TVALID,
    input  logic               out_V_V_TREADY,
    output logic [CNT_W-1:0]   count,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [CNT_W-1:0]   max_count,
    input  logic               max_clr,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0]   CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]   CNT_AE    = CNT_W'(AE_THRESH);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ram_cnt;
    logic             pf_valid;
    logic [WIDTH-1:0] pf_data;

    logic             push;
    logic             pop;
    logic             out_load;
    logic             pf_take;
    logic             rd_en;
    logic             bypass;
    out_src_e         out_src;
    logic [CNT_W-1:0] count_next;

    // Pointers wrap explicitly so any DEPTH works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Handshakes, prefetch/bypass decisions and next occupancy.
    always_comb begin
        push     = in0_V_V_TVALID & in0_V_V_TREADY;
        pop      = out_V_V_TVALID & out_V_V_TREADY;
        out_load = ~out_V_V_TVALID | pop;
        pf_take  = pf_valid & out_load;
        rd_en    = (ram_cnt != '0) & (~pf_valid | pf_take);
        bypass   = out_load & ~pf_valid & (ram_cnt == '0) & push;

        if (!out_load) begin
            out_src = OUT_HOLD;
        end else if (pf_valid) begin
            out_src = OUT_FROM_PF;
        end else if (bypass) begin
            out_src = OUT_BYPASS;
        end else begin
            out_src = OUT_EMPTY;
        end

        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (ap_clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (in0_V_V_TDATA),
        .re    (rd_en & ~flush),
        .raddr (rd_ptr),
        .rdata (pf_data)
    );

    // Pointer, RAM-occupancy, prefetch-valid and total-occupancy bookkeeping.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            pf_valid <= 1'b0;
            count    <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            pf_valid <= 1'b0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en | bypass) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            ram_cnt <= ram_cnt + CNT_W'(push) - CNT_W'(rd_en | bypass);
            if (rd_en) begin
                pf_valid <= 1'b1;
            end else if (pf_take) begin
                pf_valid <= 1'b0;
            end
            count <= count_next;
        end
    end

    // Output register: oldest word first, prefetch stage before the bypass.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_V_V_TDATA  <= '0;
            out_V_V_TVALID <= 1'b0;
        end else if (flush) begin
            out_V_V_TDATA  <= '0;
            out_V_V_TVALID <= 1'b0;
        end else begin
            case (out_src)
                OUT_FROM_PF: begin
                    out_V_V_TDATA  <= pf_data;
                    out_V_V_TVALID <= 1'b1;
                end
                OUT_BYPASS: begin
                    out_V_V_TDATA  <= in0_V_V_TDATA;
                    out_V_V_TVALID <= 1'b1;
                end
                OUT_EMPTY: begin
                    out_V_V_TVALID <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Input ready and occupancy flags, registered from the next occupancy.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            in0_V_V_TREADY <= 1'b0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
        end else begin
            in0_V_V_TREADY <= ~flush & (count_next < CNT_DEPTH);
            almost_full    <= (count_next >= CNT_AF);
            almost_empty   <= (count_next <= CNT_AE);
        end
    end

    // Sizing monitor: peak occupancy and saturating input-stall counter.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            max_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (max_clr) begin
                max_count <= count_next;
            end else if (count_next > max_count) begin
                max_count <= count_next;
            end
            if (in0_V_V_TVALID & ~in0_V_V_TREADY & (stall_cycles != STALL_MAX)) begin
                stall_cycles <= stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_streaming_fifo_mon.sv
// Self-checking bench for streaming_fifo_mon (DEPTH=8, WIDTH=16, AF=6, AE=2).
// A queue-based model tracks contents, ready, flags, peak occupancy and stall
// cycles from the handshake rules; every cycle is checked against it.
module tb_streaming_fifo_mon;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int AF      = 6;
    localparam int AE      = 2;
    localparam int STALL_W = 32;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               flush;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   count;
    logic               almost_full;
    logic               almost_empty;
    logic [CNT_W-1:0]   max_count;
    logic               max_clr;
    logic [STALL_W-1:0] stall_cycles;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [WIDTH-1:0] model_q[$];
    bit               m_ready;
    int               m_max;
    int unsigned      m_stall;

    always #5 ap_clk = ~ap_clk;

    streaming_fifo_mon #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE),
        .STALL_W   (STALL_W)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .flush          (flush),
        .in0_V_V_TDATA  (in_data),
        .in0_V_V_TVALID (in_valid),
        .in0_V_V_TREADY (in_ready),
        .out_V_V_TDATA  (out_data),
        .out_V_V_TVALID (out_valid),
        .out_V_V_TREADY (out_ready),
        .count          (count),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .max_count      (max_count),
        .max_clr        (max_clr),
        .stall_cycles   (stall_cycles)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        m_ready = 1'b0;
        m_max   = 0;
        m_stall = 0;
    endtask

    // One clock cycle: drive inputs, advance the model, then check outputs.
    task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] data,
                                 input logic ordy, input logic fl, input logic clr);
        bit               do_push;
        bit               do_pop;
        bit               was_empty;
        bit               held;
        logic [WIDTH-1:0] held_data;
        in_valid  = vld;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        max_clr   = clr;
        #3;
        do_push   = vld && m_ready && !fl;
        do_pop    = out_valid && ordy && !fl;
        held      = out_valid && !ordy && !fl;
        held_data = out_data;
        was_empty = (model_q.size() == 0) && do_push;
        if (vld && !m_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (do_pop) begin
            checkOutput("pop_nonempty", 32'(model_q.size() != 0), 32'd1);
            if (model_q.size() != 0) begin
                checkOutput("pop_data", 32'(out_data), 32'(model_q[0]));
                void'(model_q.pop_front());
            end
        end
        if (fl) model_q.delete();
        else if (do_push) model_q.push_back(data);
        if (fl) m_max = clr ? 0 : m_max;
        else if (clr) m_max = model_q.size();
        else if (model_q.size() > m_max) m_max = model_q.size();
        m_ready = !fl && (model_q.size() < DEPTH);
        @(posedge ap_clk);
        #1;
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(m_ready));
        checkOutput("almost_full", 32'(almost_full), 32'(model_q.size() >= AF));
        checkOutput("almost_empty", 32'(almost_empty), 32'(model_q.size() <= AE));
        checkOutput("max_count", 32'(max_count), 32'(m_max));
        checkOutput("stall_cycles", stall_cycles, m_stall);
        if (model_q.size() == 0) checkOutput("out_valid_empty", 32'(out_valid), 32'd0);
        if (was_empty) begin
            checkOutput("latency_valid", 32'(out_valid), 32'd1);
            checkOutput("latency_data", 32'(out_data), 32'(data));
        end
        if (held) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", 32'(out_data), 32'(held_data));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (model_q.size() == 0) break;
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drained", 32'(count), 32'd0);
    endtask

    initial begin
        ap_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; max_clr = 1'b0;
        modelReset();
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_max", 32'(max_count), 32'd0);
        checkOutput("rst_stall", stall_cycles, 32'd0);
        checkOutput("rst_ae", 32'(almost_empty), 32'd1);
        checkOutput("rst_af", 32'(almost_full), 32'd0);
        ap_rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("ready_after_release", 32'(in_ready), 32'd1);

        $display("[TB] fill to full and stall");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("full_count", 32'(count), 32'd8);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        checkOutput("full_af", 32'(almost_full), 32'd1);
        checkOutput("full_max", 32'(max_count), 32'd8);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("stall_three", stall_cycles, 32'd3);

        $display("[TB] pop from full with refused push");
        applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
        checkOutput("full_pop_count", 32'(count), 32'd7);
        checkOutput("full_pop_ready", 32'(in_ready), 32'd1);
        drain();

        $display("[TB] continuous stream 0..99");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("steady_count", 32'(count), 32'd1);
        end
        drain();

        $display("[TB] single word latency and random backpressure");
        applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_valid", 32'(out_valid), 32'd1);
        checkOutput("a5_data", 32'(out_data), 32'hA5A5);
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        drain();

        $display("[TB] flush and max clear");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_empty_max", 32'(max_count), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_max", 32'(max_count), 32'd5);
        applyStimulus(1'b1, 16'h0BEE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        checkOutput("post_flush_data", 32'(out_data), 32'hBEEF);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_max", 32'(max_count), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_clr_max", 32'(max_count), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_count", 32'(count), 32'd4);
        #2;
        ap_rst = 1'b1;
        #1;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_stall", stall_cycles, 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_max", 32'(max_count), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
